// File: rtl/sram_1r1w_access_ctrl.sv
// ---------------------------------------------------------------------------
// sram_1r1w_access_ctrl
//
// Purpose:
//   Client-side controller for a 1R1W synchronous SRAM macro with a
//   registered read address (data appears the cycle after sram_R0_en).
//   After reset it zero-fills the array, then offers valid/ready read and
//   write ports. Read data passes through a 2-entry in-order response FIFO,
//   so clients never see the macro's one-cycle data window. Same-cycle
//   read/write collisions are resolved write-first inside the controller,
//   so the macro's own collision behaviour does not matter.
//
// Ports:
//   clock, reset_n              clock / asynchronous active-low reset
//   rd_req_valid/ready/addr     read request handshake
//   rd_resp_valid/ready/data    read response handshake
//   wr_valid/ready/addr/data    write handshake (no buffering)
//   init_done                   high once the zeroing sweep has completed
//   sram_R0_en/addr, sram_R0_data   macro read port
//   sram_W0_en/addr/data            macro write port
// ---------------------------------------------------------------------------
module sram_1r1w_access_ctrl #(
    parameter int DEPTH   = 512,
    parameter int AW      = 9,
    parameter int DW      = 51,
    parameter int INIT_EN = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          rd_req_valid,
    output logic          rd_req_ready,
    input  logic [AW-1:0] rd_req_addr,
    output logic          rd_resp_valid,
    input  logic          rd_resp_ready,
    output logic [DW-1:0] rd_resp_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          init_done,
    output logic          sram_R0_en,
    output logic [AW-1:0] sram_R0_addr,
    input  logic [DW-1:0] sram_R0_data,
    output logic          sram_W0_en,
    output logic [AW-1:0] sram_W0_addr,
    output logic [DW-1:0] sram_W0_data
);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          init_done_q;

    logic          rd_acc, wr_acc, bypass;
    logic [AW-1:0] raddr_q;

    logic          s1_vld_q, s1_byp_q;
    logic [DW-1:0] s1_bdata_q;

    logic [DW-1:0] fifo_q [2];
    logic          rptr_q, wptr_q;
    logic [1:0]    fifo_cnt_q;
    logic          push, pop;
    logic [DW-1:0] push_data;
    logic [2:0]    occ;

    // Occupancy the FIFO will have once this cycle's pop and the s1 push
    // have both happened; a new accept is allowed only if it still fits.
    assign pop  = (fifo_cnt_q != 2'd0) && rd_resp_ready;
    assign occ  = 3'(fifo_cnt_q) + 3'(s1_vld_q) - 3'(pop);

    // FSM next state and port decode. init_done_q doubles as the "running"
    // qualifier so the readys stay low while reset is applied, even when
    // the sweep is disabled and the FSM resets straight into ST_RUN.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sram_W0_en   = 1'b0;
        sram_W0_addr = cnt_q;
        sram_W0_data = '0;
        wr_ready     = 1'b0;
        rd_req_ready = 1'b0;
        case (state_q)
            ST_INIT: begin
                // Gated by reset_n so no zeroing write is issued while the
                // controller is still held in reset.
                sram_W0_en = reset_n;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (init_done_q) begin
                    wr_ready     = 1'b1;
                    rd_req_ready = (occ < 3'd2);
                    sram_W0_en   = wr_valid;
                    sram_W0_addr = wr_addr;
                    sram_W0_data = wr_data;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= (state_d == ST_RUN);
        end
    end

    assign init_done = init_done_q;

    // Request stage (T): address goes straight to the macro on accept and
    // is otherwise held so the macro address pins stay quiet.
    assign rd_acc       = rd_req_valid && rd_req_ready;
    assign wr_acc       = wr_valid && wr_ready;
    assign bypass       = rd_acc && wr_acc && (rd_req_addr == wr_addr);
    assign sram_R0_en   = rd_acc;
    assign sram_R0_addr = rd_acc ? rd_req_addr : raddr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            raddr_q    <= '0;
            s1_vld_q   <= 1'b0;
            s1_byp_q   <= 1'b0;
            s1_bdata_q <= '0;
        end else begin
            s1_vld_q <= rd_acc;
            s1_byp_q <= bypass;
            if (rd_acc) begin
                raddr_q <= rd_req_addr;
            end
            if (bypass) begin
                s1_bdata_q <= wr_data;
            end
        end
    end

    // s1 stage (T+1): macro data is only valid now, so it is captured into
    // the FIFO unconditionally; the readiness check above guarantees room.
    assign push      = s1_vld_q;
    assign push_data = s1_byp_q ? s1_bdata_q : sram_R0_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            rptr_q     <= 1'b0;
            wptr_q     <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= push_data;
                wptr_q         <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
        end
    end

    // Response stage: FIFO head drives the client.
    assign rd_resp_valid = (fifo_cnt_q != 2'd0);
    assign rd_resp_data  = fifo_q[rptr_q];

endmodule

// File: tb/tb_sram_1r1w_access_ctrl.sv
module tb_sram_1r1w_access_ctrl;

    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int DW    = 51;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          rd_req_valid, rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic          rd_resp_valid, rd_resp_ready;
    logic [DW-1:0] rd_resp_data;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          init_done;
    logic          sram_R0_en;
    logic [AW-1:0] sram_R0_addr;
    logic [DW-1:0] sram_R0_data;
    logic          sram_W0_en;
    logic [AW-1:0] sram_W0_addr;
    logic [DW-1:0] sram_W0_data;

    always #5 clock = ~clock;

    sram_1r1w_access_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .INIT_EN(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_done(init_done),
        .sram_R0_en(sram_R0_en), .sram_R0_addr(sram_R0_addr), .sram_R0_data(sram_R0_data),
        .sram_W0_en(sram_W0_en), .sram_W0_addr(sram_W0_addr), .sram_W0_data(sram_W0_data)
    );

    // Macro model: registered read address, read data valid one cycle after
    // the enable and garbage otherwise; same-edge collision returns old data.
    logic [DW-1:0] smem [DEPTH];
    logic [DW-1:0] s_rq, s_junk;
    logic          s_rv = 1'b0;
    always @(posedge clock) begin
        if (sram_W0_en) smem[sram_W0_addr] <= sram_W0_data;
        if (sram_R0_en) s_rq <= smem[sram_R0_addr];
        s_rv   <= sram_R0_en;
        s_junk <= DW'({$urandom(), $urandom()});
    end
    assign sram_R0_data = s_rv ? s_rq : s_junk;

    // Reference model: what the array holds from the client's viewpoint.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  acc_rd, acc_wr;
    logic [DW-1:0] mon_exp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every accepted response is compared against the queue head.
    always @(negedge clock) begin
        if (reset_n && rd_resp_valid && rd_resp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_unexpected: got 0x%0h, expected no response", rd_resp_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("resp_data", 64'(rd_resp_data), 64'(mon_exp));
            end
        end
    end

    function automatic logic [DW-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // One clock of stimulus; accepts are judged just before the next edge.
    task automatic cyc(input bit rv, input logic [AW-1:0] ra, input bit wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd, input bit rr);
        @(posedge clock);
        #1;
        rd_req_valid  = rv;
        rd_req_addr   = ra;
        wr_valid      = wv;
        wr_addr       = wa;
        wr_data       = wd;
        rd_resp_ready = rr;
        @(negedge clock);
        acc_rd = rd_req_valid && rd_req_ready;
        acc_wr = wr_valid && wr_ready;
        if (acc_rd) exp_q.push_back((acc_wr && wa == ra) ? wd : ref_mem[ra]);
        if (acc_wr) ref_mem[wa] = wd;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic check_reset();
        chk("rst_init_done", 64'(init_done), 64'(0));
        chk("rst_rd_req_ready", 64'(rd_req_ready), 64'(0));
        chk("rst_wr_ready", 64'(wr_ready), 64'(0));
        chk("rst_rd_resp_valid", 64'(rd_resp_valid), 64'(0));
        chk("rst_rd_resp_data", 64'(rd_resp_data), 64'(0));
        chk("rst_sram_ctl", 64'({sram_R0_en, sram_W0_en}), 64'(0));
        chk("rst_sram_addr", 64'({sram_R0_addr, sram_W0_addr}), 64'(0));
        chk("rst_sram_wdata", 64'(sram_W0_data), 64'(0));
    endtask

    // Called just after a negedge: assert reset asynchronously mid-cycle.
    task automatic assert_reset();
        #2;
        reset_n       = 1'b0;
        rd_req_valid  = 1'b0;
        wr_valid      = 1'b0;
        rd_resp_ready = 1'b0;
        #1;
        check_reset();
        exp_q.delete();
    endtask

    // Release reset and watch the zeroing sweep; stop_at >= 0 returns early.
    task automatic run_init(input int stop_at);
        int ncyc;
        ncyc = -1;
        @(posedge clock);
        #1;
        reset_n      = 1'b1;
        rd_req_valid = 1'b1;
        wr_valid     = 1'b1;
        wr_data      = '1;
        for (int i = 0; i < DEPTH + 8; i++) begin
            @(negedge clock);
            if (init_done) begin
                rd_req_valid = 1'b0;
                wr_valid     = 1'b0;
                ncyc = i;
                break;
            end
            chk("init_cycle",
                64'({sram_W0_en, rd_req_ready, wr_ready, sram_R0_en, (sram_W0_data != '0), sram_W0_addr}),
                64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, AW'(i)}));
            if (i == stop_at) return;
        end
        rd_req_valid = 1'b0;
        wr_valid     = 1'b0;
        chk("init_len", 64'(ncyc), 64'(DEPTH));
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    endtask

    initial begin
        int nacc, nv, first, last;
        logic [AW-1:0] ra, wa;
        bit rv, wv, rr;

        for (int a = 0; a < DEPTH; a++) smem[a] = rnd_data();
        reset_n = 1'b0; rd_req_valid = 1'b0; rd_req_addr = '0; rd_resp_ready = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset();
        run_init(-1);

        // Read of a swept location returns zero.
        cyc(1'b1, 9'h1A5, 1'b0, '0, '0, 1'b1);
        chk("acc_1a5", 64'(acc_rd), 64'(1));
        idle(3);

        // Write then read with exact 2-cycle latency.
        cyc(1'b0, '0, 1'b1, 9'h010, 51'h7_FFFF_FFFF_FFFF, 1'b1);
        cyc(1'b1, 9'h010, 1'b0, '0, '0, 1'b1);
        chk("lat_acc", 64'(acc_rd), 64'(1));
        idle(1);
        chk("lat_t1_valid", 64'(rd_resp_valid), 64'(0));
        idle(1);
        chk("lat_t2_valid", 64'(rd_resp_valid), 64'(1));
        idle(3);

        // Collisions: same-cycle write-first, next-cycle write unseen.
        cyc(1'b0, '0, 1'b1, 9'h123, 51'h1234, 1'b1);
        cyc(1'b1, 9'h123, 1'b1, 9'h123, 51'h5A5A5, 1'b1);
        chk("coll_acc", 64'({acc_rd, acc_wr}), 64'(3));
        cyc(1'b1, 9'h123, 1'b0, '0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1, 9'h123, 51'h1, 1'b1);
        cyc(1'b1, 9'h123, 1'b0, '0, '0, 1'b1);
        idle(4);

        // Backpressure: two reads fit, the third waits for a pop.
        cyc(1'b0, '0, 1'b1, 9'd1, 51'h111, 1'b1);
        cyc(1'b0, '0, 1'b1, 9'd2, 51'h222, 1'b1);
        cyc(1'b0, '0, 1'b1, 9'd3, 51'h333, 1'b1);
        cyc(1'b1, 9'd1, 1'b0, '0, '0, 1'b0);
        chk("bp_acc1", 64'(acc_rd), 64'(1));
        cyc(1'b1, 9'd2, 1'b0, '0, '0, 1'b0);
        chk("bp_acc2", 64'(acc_rd), 64'(1));
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 9'd3, 1'b0, '0, '0, 1'b0);
            chk("bp_hold", 64'({acc_rd, rd_req_ready}), 64'(0));
        end
        chk("bp_resp_pending", 64'(rd_resp_valid), 64'(1));
        cyc(1'b1, 9'd3, 1'b0, '0, '0, 1'b1);
        chk("bp_acc3", 64'(acc_rd), 64'(1));
        idle(4);

        // Throughput: 16 back-to-back reads, 16 consecutive responses.
        nacc = 0; nv = 0; first = -1; last = -1;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) cyc(1'b1, AW'(9'h040 + i), 1'b0, '0, '0, 1'b1);
            else        cyc(1'b0, '0, 1'b0, '0, '0, 1'b1);
            if (i < 16 && acc_rd) nacc++;
            if (rd_resp_valid) begin
                nv++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("tp_accepts", 64'(nacc), 64'(16));
        chk("tp_resp_cycles", 64'(nv), 64'(16));
        chk("tp_first_last", 64'({first[7:0], last[7:0]}), 64'({8'd2, 8'd17}));
        idle(2);

        // Randomized traffic, biased toward a few addresses for collisions.
        for (int i = 0; i < 1500; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            wv = ($urandom_range(0, 2) != 0);
            rr = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wa = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            cyc(rv, ra, wv, wa, rnd_data(), rr);
        end
        idle(6);
        chk("rand_drained", 64'(exp_q.size()), 64'(0));

        // Reset with two responses pending, then mid-sweep reset at cnt=200.
        cyc(1'b1, 9'd1, 1'b0, '0, '0, 1'b0);
        cyc(1'b1, 9'd2, 1'b0, '0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0, '0, '0, 1'b0);
        chk("pend_two", 64'({rd_resp_valid, rd_req_ready}), 64'(2));
        assert_reset();
        run_init(200);
        assert_reset();
        run_init(-1);
        cyc(1'b1, 9'd1, 1'b0, '0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1, 9'd7, 51'h7777, 1'b1);
        cyc(1'b1, 9'd7, 1'b0, '0, '0, 1'b1);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1);
        idle(2);
        chk("final_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
